// File: rtl/shared_mem_pkg.sv
// rtl/shared_mem_pkg.sv - shared types and constants for shared_mem_responder
package shared_mem_pkg;

    localparam int SMEM_DEPTH_DEF = 256;
    localparam int SMEM_WAIT_DEF  = 2;
    localparam int SMEM_DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } smem_state_t;

    // Misaligned, or any bit above the word-index field set.
    function automatic logic smem_addr_fault(input logic [31:0] addr, input int idx_w);
        return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 2)) != 32'h0);
    endfunction

endpackage

// File: rtl/smem_array.sv
// rtl/smem_array.sv - single-port synchronous RAM, registered read, no reset
module smem_array
    import shared_mem_pkg::*;
#(
    parameter int DEPTH = SMEM_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [SMEM_DATA_W-1:0]     wdata,
    output logic [SMEM_DATA_W-1:0]     rdata_q
);

    logic [SMEM_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata_q <= mem[idx];
    end

endmodule

// File: rtl/shared_mem_responder.sv
// rtl/shared_mem_responder.sv - wait-state shared-memory responder; SHARED_MEM_STATS_EN enables access counters
module shared_mem_responder
    import shared_mem_pkg::*;
#(
    parameter int DEPTH       = SMEM_DEPTH_DEF,
    parameter int WAIT_CYCLES = SMEM_WAIT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sharedAccess,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            addr,
    input  logic [SMEM_DATA_W-1:0] wdata,
    output logic [SMEM_DATA_W-1:0] rdata,
    output logic                   ready,
    output logic                   busy,
    output logic                   err,
    output logic [31:0]            rd_count,
    output logic [31:0]            wr_count
);

    localparam int IDX_W = $clog2(DEPTH);

    smem_state_t            state;
    logic [7:0]             wait_cnt;
    logic [IDX_W-1:0]       idx_q;
    logic [SMEM_DATA_W-1:0] wdata_q;
    logic                   op_wr;
    logic                   op_fault;
    logic                   op_conflict;

    logic                   req;
    logic                   access_now;
    logic                   ram_we;
    logic [IDX_W-1:0]       ram_idx;
    logic [SMEM_DATA_W-1:0] ram_rdata;

    assign req        = sharedAccess & (mem_read | mem_write);
    assign access_now = (state == WAIT) && (wait_cnt == 8'd0);
    assign ram_we     = access_now && op_wr && !op_fault;

    // The RAM reads the live address while idle so that with zero wait states
    // the registered read data is already valid on the edge entering DONE.
    assign ram_idx = (state == IDLE) ? addr[IDX_W+1:2] : idx_q;

    smem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk     (clk),
        .we      (ram_we),
        .idx     (ram_idx),
        .wdata   (wdata_q),
        .rdata_q (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            idx_q       <= '0;
            wdata_q     <= '0;
            op_wr       <= 1'b0;
            op_fault    <= 1'b0;
            op_conflict <= 1'b0;
            rdata       <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state       <= WAIT;
                        busy        <= 1'b1;
                        wait_cnt    <= 8'(WAIT_CYCLES);
                        idx_q       <= addr[IDX_W+1:2];
                        wdata_q     <= wdata;
                        op_wr       <= mem_write;
                        op_conflict <= mem_read & mem_write;
                        op_fault    <= smem_addr_fault(addr, IDX_W);
                    end
                end
                WAIT: begin
                    if (wait_cnt != 8'd0) begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end else begin
                        state <= DONE;
                        ready <= 1'b1;
                        err   <= op_fault | op_conflict;
                        if (!op_wr) begin
                            rdata <= op_fault ? '0 : ram_rdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHARED_MEM_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt_q <= 32'h0;
            wr_cnt_q <= 32'h0;
        end else if (access_now && !op_fault && !op_conflict) begin
            if (op_wr) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = 32'h0;
    assign wr_count = 32'h0;
`endif

endmodule

// File: tb/tb_shared_mem_responder.sv
// tb/tb_shared_mem_responder.sv - directed self-checking bench with expected-result scoreboard
module tb_shared_mem_responder;
    import shared_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        sa = 0, rd = 0, wr = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [31:0] rdata, rd_count, wr_count;
    logic        ready, busy, err;

    logic        sa0 = 0, rd0 = 0, wr0 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0;
    logic [31:0] rdata0, rd_count0, wr_count0;
    logic        ready0, busy0, err0;

    shared_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .sharedAccess(sa), .mem_read(rd), .mem_write(wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
        .err(err), .rd_count(rd_count), .wr_count(wr_count)
    );

    shared_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .sharedAccess(sa0), .mem_read(rd0), .mem_write(wr0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ready(ready0), .busy(busy0),
        .err(err0), .rd_count(rd_count0), .wr_count(wr_count0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] rdc;
        logic [31:0] wrc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [256];
    logic [31:0] last_rd = 32'h0;
    logic [31:0] exp_rdc = 32'h0;
    logic [31:0] exp_wrc = 32'h0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full access on the WAIT_CYCLES=2 instance; expectations come from the model.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic flt;
        int   n;
        flt   = (a[1:0] != 2'b00) || (a[31:10] != 22'h0);
        e.err = flt | (r & w);
        if (w) begin
            if (!flt) mdl[a[9:2]] = d;
`ifdef SHARED_MEM_STATS_EN
            if (!e.err) exp_wrc = exp_wrc + 1;
`endif
        end else begin
            last_rd = flt ? 32'h0 : mdl[a[9:2]];
`ifdef SHARED_MEM_STATS_EN
            if (!flt) exp_rdc = exp_rdc + 1;
`endif
        end
        e.rdata = last_rd;
        e.rdc   = exp_rdc;
        e.wrc   = exp_wrc;
        sb.push_back(e);

        @(negedge clk);
        sa = 1; rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        sa = 0; rd = 0; wr = 0; addr = 32'hFFFF_FFFF; wdata = ~d;
        chk("busy_after_accept", {31'h0, busy}, 32'h1);
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_latency", n, 32'd3);
        e = sb.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("err", {31'h0, err}, {31'h0, e.err});
        chk("rd_count", rd_count, e.rdc);
        chk("wr_count", wr_count, e.wrc);
        @(negedge clk);
        chk("busy_after_done", {31'h0, busy}, 32'h0);
        chk("ready_after_done", {31'h0, ready}, 32'h0);
    endtask

    initial begin
        int n;

        // Reset
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_flags", {29'h0, ready, busy, err}, 32'h0);
        chk("rst_counts", rd_count | wr_count, 32'h0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_dut0", {rdata0[31:3], ready0, busy0, err0}, 32'h0);

        // Write then read
        access(0, 1, 32'h10, 32'hDEAD_BEEF);
        access(1, 0, 32'h10, 32'h0);
        chk("wr_rd_value", rdata, 32'hDEAD_BEEF);

        // Zero wait states on the second instance
        @(negedge clk);
        sa0 = 1; wr0 = 1; addr0 = 32'h10; wdata0 = 32'h55;
        @(negedge clk);
        sa0 = 0; wr0 = 0;
        chk("z_busy", {31'h0, busy0}, 32'h1);
        @(negedge clk);
        chk("z_wr_ready", {31'h0, ready0}, 32'h1);
        @(negedge clk);
        sa0 = 1; rd0 = 1; addr0 = 32'h10;
        @(negedge clk);
        chk("z_rd_not_yet", {31'h0, ready0}, 32'h0);
        @(negedge clk);
        chk("z_rd_ready", {31'h0, ready0}, 32'h1);
        chk("z_rd_data", rdata0, 32'h55);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready0 && n < 10);
        chk("z_reaccept_spacing", n, 32'd3);
        sa0 = 0; rd0 = 0;

        // Faults
        access(0, 1, 32'h0, 32'hA5A5_0000);
        access(1, 0, 32'h400, 32'h0);
        access(0, 1, 32'h2, 32'h7777_7777);
        access(1, 0, 32'h0, 32'h0);
        chk("fault_wr_dropped", rdata, 32'hA5A5_0000);

        // Simultaneous read and write
        access(1, 1, 32'h20, 32'h1234);
        access(1, 0, 32'h20, 32'h0);
        chk("conflict_readback", rdata, 32'h1234);

        // Reset during a write's WAIT phase
        access(0, 1, 32'h30, 32'h1111);
        @(negedge clk);
        sa = 1; wr = 1; addr = 32'h30; wdata = 32'hCAFE;
        @(negedge clk);
        sa = 0; wr = 0;
        chk("midrst_busy_pre", {31'h0, busy}, 32'h1);
        #2 reset = 0;
        #1;
        chk("midrst_flags", {29'h0, ready, busy, err}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        reset = 1;
        last_rd = 32'h0;
        exp_rdc = 32'h0;
        exp_wrc = 32'h0;
        access(1, 0, 32'h30, 32'h0);
        chk("midrst_word_kept", rdata, 32'h1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
